// File: rtl/nf10_tx_arb_pkg.sv
// Shared definitions for the NetFPGA-10G TX port arbiter.
// Contents: arbiter state encoding, clog2 helper, and slice-index helpers
// for flattened per-input AXI4-Stream buses.
package nf10_tx_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Low bit of slice idx in a flattened bus of w-bit lanes.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/nf10_axis_skid_reg.sv
// Two-entry AXI4-Stream register slice with registered outputs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_t*/in_tvalid     upstream beat; in_ready_c = not full
//   out_t*/out_tvalid   registered downstream beat; out_tready from sink
module nf10_axis_skid_reg #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned STRB_W = 32,
  parameter int unsigned USER_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic [STRB_W-1:0] in_tstrb,
  input  logic [USER_W-1:0] in_tuser,
  input  logic              in_tlast,
  input  logic              in_tvalid,
  output logic              in_ready_c,
  output logic [DATA_W-1:0] out_tdata,
  output logic [STRB_W-1:0] out_tstrb,
  output logic [USER_W-1:0] out_tuser,
  output logic              out_tlast,
  output logic              out_tvalid,
  input  logic              out_tready
);

  localparam int unsigned BEAT_W = DATA_W + STRB_W + USER_W + 1;

  logic [1:0]        count_q;
  logic [BEAT_W-1:0] head_q;
  logic [BEAT_W-1:0] spare_q;
  logic              valid_q;
  logic [BEAT_W-1:0] in_beat_c;
  logic              push_c;
  logic              pop_c;

  assign in_beat_c  = {in_tdata, in_tstrb, in_tuser, in_tlast};
  assign in_ready_c = (count_q != 2'd2);
  assign push_c     = in_tvalid & in_ready_c;
  assign pop_c      = valid_q & out_tready;

  assign {out_tdata, out_tstrb, out_tuser, out_tlast} = head_q;
  assign out_tvalid = valid_q;

  // head_q is the visible beat; spare_q catches the one beat that arrives
  // while the head is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      spare_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push_c) begin
            head_q  <= in_beat_c;
            valid_q <= 1'b1;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push_c && pop_c) begin
            head_q <= in_beat_c;
          end else if (push_c) begin
            spare_q <= in_beat_c;
            count_q <= 2'd2;
          end else if (pop_c) begin
            valid_q <= 1'b0;
            count_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop_c) begin
            head_q  <= spare_q;
            count_q <= 2'd1;
          end
        end
        default: begin
          count_q <= 2'd0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/nf10_tx_port_arbiter.sv
// Packet-granular round-robin arbiter sharing one TX AXI4-Stream slave
// between C_NUM_INPUTS requesters; never interleaves packets.
// Ports:
//   axi_aclk, axi_reset     clock, synchronous active-high reset
//   s_axis_*                flattened per-input streams (slice i = input i)
//   m_axis_*                registered merged stream to the 10G interface
//   pkt_cnt                 per-input completed-packet counters (32b each)
module nf10_tx_port_arbiter
  import nf10_tx_arb_pkg::*;
#(
  parameter int unsigned C_NUM_INPUTS  = 4,
  parameter int unsigned C_DATA_WIDTH  = 256,
  parameter int unsigned C_TUSER_WIDTH = 128
) (
  input  logic                                  axi_aclk,
  input  logic                                  axi_reset,
  input  logic [C_NUM_INPUTS*C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_NUM_INPUTS*C_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_NUM_INPUTS*C_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [C_NUM_INPUTS-1:0]                s_axis_tvalid,
  output logic [C_NUM_INPUTS-1:0]                s_axis_tready,
  input  logic [C_NUM_INPUTS-1:0]                s_axis_tlast,
  output logic [C_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]              m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic [C_NUM_INPUTS*32-1:0]             pkt_cnt
);

  localparam int unsigned STRB_W = C_DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = clog2(C_NUM_INPUTS);
  localparam int unsigned CNT_W  = 32;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]  cand_c;
  logic [C_NUM_INPUTS-1:0] cnt_inc_c;

  logic                     skid_ready_c;
  logic                     sel_valid_c;
  logic                     sel_last_c;
  logic                     push_c;
  logic [C_DATA_WIDTH-1:0]  sel_data_c;
  logic [STRB_W-1:0]        sel_strb_c;
  logic [C_TUSER_WIDTH-1:0] sel_user_c;

  // Granted-input mux; only meaningful while LOCKED.
  assign sel_valid_c = (state_q == LOCKED) & s_axis_tvalid[grant_q];
  assign sel_last_c  = s_axis_tlast[grant_q];
  assign sel_data_c  = s_axis_tdata[slice_lo(32'(grant_q), C_DATA_WIDTH) +: C_DATA_WIDTH];
  assign sel_strb_c  = s_axis_tstrb[slice_lo(32'(grant_q), STRB_W) +: STRB_W];
  assign sel_user_c  = s_axis_tuser[slice_lo(32'(grant_q), C_TUSER_WIDTH) +: C_TUSER_WIDTH];
  assign push_c      = sel_valid_c & skid_ready_c;

  // State register.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(C_NUM_INPUTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state, round-robin search and per-input ready decode.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    cand_c        = '0;
    s_axis_tready = '0;
    cnt_inc_c     = '0;
    case (state_q)
      IDLE: begin
        if (|s_axis_tvalid) begin
          // Walk furthest-first so the nearest requester after last_grant wins.
          for (int unsigned k = C_NUM_INPUTS; k >= 1; k--) begin
            cand_c = IDX_W'((32'(last_grant_q) + k) % C_NUM_INPUTS);
            if (s_axis_tvalid[cand_c]) grant_d = cand_c;
          end
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        s_axis_tready[grant_q] = skid_ready_c;
        if (push_c && sel_last_c) begin
          cnt_inc_c[grant_q] = 1'b1;
          last_grant_d       = grant_q;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-input packet counters; wrap naturally at 2^32.
  for (genvar i = 0; i < C_NUM_INPUTS; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge axi_aclk) begin
      if (axi_reset) cnt_q <= '0;
      else if (cnt_inc_c[i]) cnt_q <= cnt_q + 32'd1;
    end
    assign pkt_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end

  nf10_axis_skid_reg #(
    .DATA_W (C_DATA_WIDTH),
    .STRB_W (STRB_W),
    .USER_W (C_TUSER_WIDTH)
  ) u_skid (
    .clk        (axi_aclk),
    .rst        (axi_reset),
    .in_tdata   (sel_data_c),
    .in_tstrb   (sel_strb_c),
    .in_tuser   (sel_user_c),
    .in_tlast   (sel_last_c),
    .in_tvalid  (sel_valid_c),
    .in_ready_c (skid_ready_c),
    .out_tdata  (m_axis_tdata),
    .out_tstrb  (m_axis_tstrb),
    .out_tuser  (m_axis_tuser),
    .out_tlast  (m_axis_tlast),
    .out_tvalid (m_axis_tvalid),
    .out_tready (m_axis_tready)
  );

endmodule

// File: tb/tb_nf10_tx_port_arbiter.sv
// Directed self-checking bench for nf10_tx_port_arbiter.
module tb_nf10_tx_port_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 256;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned UW = 128;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic              axi_aclk;
  logic              axi_reset;
  logic [N*DW-1:0]   s_axis_tdata;
  logic [N*SW-1:0]   s_axis_tstrb;
  logic [N*UW-1:0]   s_axis_tuser;
  logic [N-1:0]      s_axis_tvalid;
  logic [N-1:0]      s_axis_tready;
  logic [N-1:0]      s_axis_tlast;
  logic [DW-1:0]     m_axis_tdata;
  logic [SW-1:0]     m_axis_tstrb;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [N*32-1:0]   pkt_cnt;

  nf10_tx_port_arbiter #(
    .C_NUM_INPUTS  (N),
    .C_DATA_WIDTH  (DW),
    .C_TUSER_WIDTH (UW)
  ) dut (
    .axi_aclk      (axi_aclk),
    .axi_reset     (axi_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_cnt       (pkt_cnt)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  int     n_cmp = 0;
  int     n_err = 0;
  beat_t  src_q [N][$];
  beat_t  out_q [$];
  beat_t  exp_q [$];
  logic [N-1:0] hold;
  logic [N-1:0] in_hs;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input int i, input int p, input int b, input bit last);
    beat_t r;
    r.d = {8{8'(i), 8'(p), 8'(b), 8'hA5}};
    r.s = last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    r.u = {4{8'(i), 8'(p), 8'(b), 8'h5A}};
    r.l = last;
    return r;
  endfunction

  function automatic beat_t m_beat();
    beat_t r;
    r = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
    return r;
  endfunction

  task automatic add_pkt(input int i, input int p, input int len);
    for (int b = 0; b < len; b++) src_q[i].push_back(mk(i, p, b, b == len - 1));
  endtask

  task automatic add_exp(input int i, input int p, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back(mk(i, p, b, b == len - 1));
  endtask

  task automatic drive_inputs();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b = '0;
      if (src_q[i].size() != 0 && !hold[i]) b = src_q[i][0];
      s_axis_tvalid[i]          = (src_q[i].size() != 0) && !hold[i];
      s_axis_tdata[i*DW +: DW]  = b.d;
      s_axis_tstrb[i*SW +: SW]  = b.s;
      s_axis_tuser[i*UW +: UW]  = b.u;
      s_axis_tlast[i]           = b.l;
    end
  endtask

  // One clock: sample handshakes on the falling edge, update drive 2ns after rising edge.
  task automatic cycle();
    beat_t tmp;
    @(negedge axi_aclk);
    if (m_axis_tvalid && m_axis_tready) out_q.push_back(m_beat());
    in_hs = s_axis_tvalid & s_axis_tready;
    @(posedge axi_aclk);
    #2;
    for (int i = 0; i < N; i++) if (in_hs[i]) tmp = src_q[i].pop_front();
    drive_inputs();
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) src_q[i].delete();
    out_q.delete();
    exp_q.delete();
    hold = '0;
  endtask

  task automatic do_reset();
    axi_reset = 1'b1;
    clear_all();
    drive_inputs();
    cycle();
    cycle();
    axi_reset = 1'b0;
    clear_all();
  endtask

  task automatic drain(input string tag, input int budget);
    int b;
    b = budget;
    while (out_q.size() < exp_q.size() && b > 0) begin
      cycle();
      b--;
    end
    repeat (3) cycle();
    chk({tag, "_n"}, out_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
      chk($sformatf("%s_%0d", tag, k), out_q[k], exp_q[k]);
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_src(input string tag, input int i, input int size, input int budget);
    int b;
    b = budget;
    while (src_q[i].size() > size && b > 0) begin
      cycle();
      b--;
    end
    chk(tag, src_q[i].size(), size);
  endtask

  initial begin
    axi_reset     = 1'b1;
    m_axis_tready = 1'b1;
    hold          = '0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = '0;

    // Reset state
    do_reset();
    chk("rst_mvalid", m_axis_tvalid, 1'b0);
    chk("rst_mlast", m_axis_tlast, 1'b0);
    chk("rst_mbeat", m_beat(), '0);
    chk("rst_tready", s_axis_tready, 4'b0000);
    chk("rst_cnt", pkt_cnt, '0);

    // Single 3-beat packet on input 2
    do_reset();
    add_pkt(2, 0, 3);
    drive_inputs();
    cycle();
    chk("sp_grant", s_axis_tready, 4'b0100);
    chk("sp_bubble", m_axis_tvalid, 1'b0);
    for (int b = 0; b < 3; b++) begin
      cycle();
      chk($sformatf("sp_lat_v%0d", b), m_axis_tvalid, 1'b1);
      chk($sformatf("sp_lat_b%0d", b), m_beat(), mk(2, 0, b, b == 2));
    end
    chk("sp_cnt", pkt_cnt, {32'd0, 32'd1, 32'd0, 32'd0});
    add_exp(2, 0, 3);
    drain("sp_out", 20);

    // Fairness: all inputs offer two 2-beat packets
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) begin
        add_pkt(i, p, 2);
        add_exp(i, p, 2);
      end
    drive_inputs();
    drain("fair", 100);
    chk("fair_cnt", pkt_cnt, {32'd2, 32'd2, 32'd2, 32'd2});

    // Backpressure during a 6-beat packet
    do_reset();
    m_axis_tready = 1'b0;
    add_pkt(0, 0, 6);
    drive_inputs();
    cycle();
    cycle();
    cycle();
    chk("bp_rdy", s_axis_tready, 4'b0000);
    chk("bp_buf", src_q[0].size(), 4);
    chk("bp_valid", m_axis_tvalid, 1'b1);
    chk("bp_head", m_beat(), mk(0, 0, 0, 0));
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk($sformatf("bp_hold%0d", c), {m_axis_tvalid, m_beat()}, {1'b1, mk(0, 0, 0, 0)});
      chk($sformatf("bp_rdy%0d", c), s_axis_tready, 4'b0000);
    end
    m_axis_tready = 1'b1;
    add_exp(0, 0, 6);
    drain("bp_out", 30);

    // Mid-packet gap on input 1 while input 0 requests
    do_reset();
    add_pkt(1, 0, 3);
    drive_inputs();
    wait_src("gap_wait", 1, 1, 20);
    hold[1] = 1'b1;
    add_pkt(0, 0, 2);
    drive_inputs();
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk($sformatf("gap_lock%0d", c), s_axis_tready, 4'b0010);
    end
    hold[1] = 1'b0;
    drive_inputs();
    add_exp(1, 0, 3);
    add_exp(0, 0, 2);
    drain("gap_out", 30);
    chk("gap_cnt", pkt_cnt, {32'd0, 32'd0, 32'd1, 32'd1});

    // Reset in the middle of a 4-beat packet
    do_reset();
    add_pkt(0, 0, 1);
    add_pkt(1, 0, 4);
    drive_inputs();
    wait_src("mr_wait", 1, 3, 20);
    axi_reset = 1'b1;
    cycle();
    chk("mr_mvalid", m_axis_tvalid, 1'b0);
    chk("mr_tready", s_axis_tready, 4'b0000);
    chk("mr_cnt", pkt_cnt, '0);
    axi_reset = 1'b0;
    clear_all();
    add_pkt(1, 1, 1);
    add_pkt(0, 1, 1);
    drive_inputs();
    add_exp(0, 1, 1);
    add_exp(1, 1, 1);
    drain("mr_prio", 20);

    // Counter wrap on input 3
    do_reset();
    force dut.g_cnt[3].cnt_q = 32'hFFFF_FFFF;
    cycle();
    release dut.g_cnt[3].cnt_q;
    chk("wrap_pre", pkt_cnt, {32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0});
    add_pkt(3, 0, 1);
    drive_inputs();
    add_exp(3, 0, 1);
    drain("wrap_out", 20);
    chk("wrap_cnt", pkt_cnt, {32'd0, 32'd0, 32'd0, 32'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
